// File: rtl/tmds_ddr_serializer_if.sv
// -----------------------------------------------------------------------------
// tmds_ddr_serializer_if
// Load handshake between a symbol source and the TMDS DDR serializer.
//   load_valid : source offers one symbol set on load_words
//   load_ready : serializer accepts the set on this rising edge
//   load_words : lane c occupies bits [c*WORD_WIDTH +: WORD_WIDTH]
// Modports: master = symbol source, slave = serializer.
// -----------------------------------------------------------------------------
interface tmds_ddr_serializer_if #(
    parameter int CHANNELS   = 4,
    parameter int WORD_WIDTH = 10
);
    logic                           load_valid;
    logic                           load_ready;
    logic [CHANNELS*WORD_WIDTH-1:0] load_words;

    modport master (
        output load_valid,
        output load_words,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_words,
        output load_ready
    );
endinterface

// File: rtl/tmds_ddr_serializer.sv
// -----------------------------------------------------------------------------
// tmds_ddr_serializer
// Multi-lane TMDS parallel-to-DDR serializer running in the serial clock domain
// (WORD_WIDTH/2 clocks per symbol). A one-entry buffer decouples the load
// handshake from the symbol boundary; each lane shifts out two bits per clock.
// An idle symbol is substituted on every lane when the buffer is empty at a
// symbol boundary, and a sticky underrun flag records it.
// Ports:
//   clock          : serial-rate clock
//   areset         : asynchronous active-high reset
//   load_if        : slave side of the load handshake (valid/ready/words)
//   pair_out       : lane c on [2c+1:2c]; [2c+1] is the rising-edge bit
//   word_start     : pair_out carries the first pair of a symbol
//   underrun       : sticky idle-insertion flag
//   clear_underrun : synchronous clear of underrun (a new underrun wins)
// -----------------------------------------------------------------------------
module tmds_ddr_serializer #(
    parameter int                    CHANNELS    = 4,
    parameter int                    WORD_WIDTH  = 10,
    parameter int                    LSB_FIRST   = 1,
    parameter logic [CHANNELS-1:0]   INVERT_MASK = {CHANNELS{1'b0}},
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD   = 10'b1101010100
) (
    input  logic                    clock,
    input  logic                    areset,
    tmds_ddr_serializer_if.slave    load_if,
    output logic [CHANNELS*2-1:0]   pair_out,
    output logic                    word_start,
    output logic                    underrun,
    input  logic                    clear_underrun
);

    localparam int              P          = WORD_WIDTH / 2;
    localparam int              PW         = (P > 1) ? $clog2(P) : 1;
    localparam logic [PW-1:0]   LAST_PHASE = PW'(P - 1);
    localparam logic [PW-1:0]   ZERO_PHASE = {PW{1'b0}};

    if (((WORD_WIDTH % 2) != 0) || (WORD_WIDTH < 2) || (CHANNELS < 1) || (CHANNELS > 8)) begin : g_param_check
        $error("tmds_ddr_serializer: WORD_WIDTH must be even and >= 2, CHANNELS must be 1..8");
    end

    logic [WORD_WIDTH-1:0]          sr_r [CHANNELS];
    logic [PW-1:0]                  phase_r;
    logic                           buf_valid_r;
    logic [CHANNELS*WORD_WIDTH-1:0] buf_data_r;
    logic                           underrun_r;
    logic                           started_r;

    logic                           at_boundary_s;
    logic                           load_ready_s;
    logic                           transfer_s;

    // Moves the next pair of a shift register into the output position.
    function automatic logic [WORD_WIDTH-1:0] advance(input logic [WORD_WIDTH-1:0] w);
        logic [WORD_WIDTH-1:0] r;
        if (LSB_FIRST != 0) begin
            r = w >> 2'd2;
        end else begin
            r = w << 2'd2;
        end
        return r;
    endfunction

    // Pair currently at the output end of a shift register, first bit in [1].
    function automatic logic [1:0] head_pair(input logic [WORD_WIDTH-1:0] w);
        logic [1:0] r;
        if (LSB_FIRST != 0) begin
            r = {w[0], w[1]};
        end else begin
            r = {w[WORD_WIDTH-1], w[WORD_WIDTH-2]};
        end
        return r;
    endfunction

    // Handshake decode: the buffer can take a set when empty or when it drains this edge.
    always_comb begin
        at_boundary_s = (phase_r == LAST_PHASE);
        load_ready_s  = !buf_valid_r || at_boundary_s;
        transfer_s    = load_if.load_valid && load_ready_s;
    end

    assign load_if.load_ready = load_ready_s;

    // Phase counter; reset parks it on the last slot so the first edge is a boundary.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            phase_r <= LAST_PHASE;
        end else if (at_boundary_s) begin
            phase_r <= ZERO_PHASE;
        end else begin
            phase_r <= phase_r + PW'(1);
        end
    end

    // One-entry buffer: a transfer always fills it, an unrefilled boundary drains it.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= {(CHANNELS*WORD_WIDTH){1'b0}};
        end else if (transfer_s) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= load_if.load_words;
        end else if (at_boundary_s) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= buf_data_r;
        end else begin
            buf_valid_r <= buf_valid_r;
            buf_data_r  <= buf_data_r;
        end
    end

    // Per-lane shift registers: reload at the boundary (buffer or idle), else advance.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sr_r[c] <= {WORD_WIDTH{1'b0}};
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (at_boundary_s) begin
                    if (buf_valid_r) begin
                        sr_r[c] <= buf_data_r[c*WORD_WIDTH +: WORD_WIDTH];
                    end else begin
                        sr_r[c] <= IDLE_WORD;
                    end
                end else begin
                    sr_r[c] <= advance(sr_r[c]);
                end
            end
        end
    end

    // Sticky underrun; a new idle insertion takes priority over the clear.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            underrun_r <= 1'b0;
        end else if (at_boundary_s && !buf_valid_r) begin
            underrun_r <= 1'b1;
        end else if (clear_underrun) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    // Remembers that the shift registers hold a real symbol, gating word_start after reset.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            started_r <= 1'b0;
        end else if (at_boundary_s) begin
            started_r <= 1'b1;
        end else begin
            started_r <= started_r;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign pair_out[2*c +: 2] = head_pair(sr_r[c]) ^ {2{INVERT_MASK[c]}};
    end

    assign word_start = started_r && (phase_r == ZERO_PHASE);
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_tmds_ddr_serializer.sv
// -----------------------------------------------------------------------------
// tb_tmds_ddr_serializer
// Self-checking bench for tmds_ddr_serializer. Instance a uses default
// parameters and is tracked cycle by cycle by a reference model whose symbol
// queue is filled on every accepted transfer. Instance b (MSB first, lane 3
// inverted) checks the alternate output mapping.
// -----------------------------------------------------------------------------
module tb_tmds_ddr_serializer;

    localparam int            CH   = 4;
    localparam int            W    = 10;
    localparam int            P    = W / 2;
    localparam logic [W-1:0]  IDLE = 10'b1101010100;

    logic clock  = 1'b0;
    logic areset = 1'b1;
    logic clr_a  = 1'b0;
    logic clr_b  = 1'b0;

    tmds_ddr_serializer_if #(.CHANNELS(CH), .WORD_WIDTH(W)) a_if ();
    tmds_ddr_serializer_if #(.CHANNELS(CH), .WORD_WIDTH(W)) b_if ();

    logic [2*CH-1:0] pair_a, pair_b;
    logic            ws_a, ws_b, ur_a, ur_b;

    tmds_ddr_serializer #(
        .CHANNELS(CH), .WORD_WIDTH(W), .LSB_FIRST(1),
        .INVERT_MASK(4'b0000), .IDLE_WORD(IDLE)
    ) dut_a (
        .clock(clock), .areset(areset), .load_if(a_if),
        .pair_out(pair_a), .word_start(ws_a), .underrun(ur_a), .clear_underrun(clr_a)
    );

    tmds_ddr_serializer #(
        .CHANNELS(CH), .WORD_WIDTH(W), .LSB_FIRST(0),
        .INVERT_MASK(4'b1000), .IDLE_WORD(IDLE)
    ) dut_b (
        .clock(clock), .areset(areset), .load_if(b_if),
        .pair_out(pair_b), .word_start(ws_b), .underrun(ur_b), .clear_underrun(clr_b)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model of instance a.
    int                  m_phase;
    logic [CH*W-1:0]     sb_q [$];
    logic [CH*W-1:0]     m_cur;
    logic                m_ur;
    logic                m_started;
    int                  n_xfer = 0;
    logic [CH*W-1:0]     idle_set = {CH{IDLE}};
    logic [CH*W-1:0]     rnd_set [128];
    logic [1:0]          idle_pairs [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b11};

    task automatic model_reset();
        m_phase   = P - 1;
        sb_q.delete();
        m_cur     = '0;
        m_ur      = 1'b0;
        m_started = 1'b0;
    endtask

    // Expected {pair_out, load_ready, word_start, underrun}, pairs taken straight from the symbol bits.
    function automatic logic [2*CH+2:0] exp_vec();
        logic [2*CH-1:0] p;
        for (int c = 0; c < CH; c++) begin
            p[2*c +: 2] = {m_cur[c*W + 2*m_phase], m_cur[c*W + 2*m_phase + 1]};
        end
        return {p, (sb_q.size() == 0) || (m_phase == P - 1), m_started && (m_phase == 0), m_ur};
    endfunction

    function automatic logic [CH*W-1:0] mk_stream(input int n);
        logic [W-1:0] l0;
        l0 = (n % 2 == 0) ? 10'h3FF : 10'h000;
        return {10'h0F0, 10'h2A5, 10'h155, l0};
    endfunction

    // Drives instance a for one clock and advances the model across the edge.
    task automatic tick(input logic valid, input logic [CH*W-1:0] words, input logic clr);
        logic rdy, xfer, set_ur;
        a_if.load_valid = valid;
        a_if.load_words = words;
        clr_a           = clr;
        rdy  = (sb_q.size() == 0) || (m_phase == P - 1);
        xfer = valid && rdy;
        @(posedge clock);
        set_ur = 1'b0;
        if (m_phase == P - 1) begin
            if (sb_q.size() != 0) begin
                m_cur = sb_q.pop_front();
            end else begin
                m_cur  = idle_set;
                set_ur = 1'b1;
            end
            m_phase   = 0;
            m_started = 1'b1;
        end else begin
            m_phase++;
        end
        if (set_ur) m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
        if (xfer) begin
            sb_q.push_back(words);
            n_xfer++;
        end
        #1;
    endtask

    task automatic test_reset();
        a_if.load_valid = 1'b0; a_if.load_words = '0; clr_a = 1'b0;
        b_if.load_valid = 1'b0; b_if.load_words = '0;
        areset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        n_checks++;
        if ({pair_a, a_if.load_ready, ws_a, ur_a} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", {pair_a, a_if.load_ready, ws_a, ur_a}, {8'h00, 3'b100});
        end
        n_checks++;
        if ({pair_b, b_if.load_ready, ws_b, ur_b} !== {8'hC0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", {pair_b, b_if.load_ready, ws_b, ur_b}, {8'hC0, 3'b100});
        end
        areset = 1'b0;
    endtask

    task automatic test_idle_after_reset();
        for (int i = 0; i < 7; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if ({pair_a, a_if.load_ready, ws_a, ur_a} !== exp_vec()) begin
                n_fail++;
                $display("FAIL idle_vec cyc %0d: got %h expected %h", i, {pair_a, a_if.load_ready, ws_a, ur_a}, exp_vec());
            end
            n_checks++;
            if ({pair_a, ur_a} !== {{CH{idle_pairs[i % 5]}}, 1'b1}) begin
                n_fail++;
                $display("FAIL idle_pairs cyc %0d: got %h expected %h", i, {pair_a, ur_a}, {{CH{idle_pairs[i % 5]}}, 1'b1});
            end
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, mk_stream(n_xfer), (i == 0) ? 1'b1 : 1'b0);
            n_checks++;
            if ({pair_a, a_if.load_ready, ws_a, ur_a} !== exp_vec()) begin
                n_fail++;
                $display("FAIL stream_vec cyc %0d: got %h expected %h", i, {pair_a, a_if.load_ready, ws_a, ur_a}, exp_vec());
            end
            if (i >= 5) begin
                n_checks++;
                if ({pair_a[3:2], ur_a} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL stream_lane1 cyc %0d: got %b expected 100", i, {pair_a[3:2], ur_a});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        a_if.load_valid = 1'b1;
        areset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        areset = 1'b0;
        for (int i = 0; i < 505; i++) begin
            tick(1'b1, rnd_set[n_xfer % 128], 1'b0);
            n_checks++;
            if ({pair_a, a_if.load_ready, ws_a, ur_a} !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_vec cyc %0d: got %h expected %h", i, {pair_a, a_if.load_ready, ws_a, ur_a}, exp_vec());
            end
            n_checks++;
            if (a_if.load_ready !== ((i % 5) == 4)) begin
                n_fail++;
                $display("FAIL b2b_ready cyc %0d: got %b expected %b", i, a_if.load_ready, ((i % 5) == 4));
            end
        end
    endtask

    task automatic test_gap_underrun();
        logic v, c;
        while (m_phase != 0) tick(1'b1, mk_stream(n_xfer), 1'b0);
        for (int i = 0; i < 45; i++) begin
            v = !((i >= 5 && i <= 14) || (i >= 25 && i <= 34));
            c = (i == 0) || (i == 20) || (i == 34);
            tick(v, mk_stream(n_xfer), c);
            n_checks++;
            if ({pair_a, a_if.load_ready, ws_a, ur_a} !== exp_vec()) begin
                n_fail++;
                $display("FAIL gap_vec cyc %0d: got %h expected %h", i, {pair_a, a_if.load_ready, ws_a, ur_a}, exp_vec());
            end
            if (i >= 14 && i <= 18) begin
                n_checks++;
                if ({pair_a, ur_a} !== {{CH{idle_pairs[i - 14]}}, 1'b1}) begin
                    n_fail++;
                    $display("FAIL gap_idle cyc %0d: got %h expected %h", i, {pair_a, ur_a}, {{CH{idle_pairs[i - 14]}}, 1'b1});
                end
            end
            if (i == 20 || i == 34) begin
                n_checks++;
                if (ur_a !== (i == 34)) begin
                    n_fail++;
                    $display("FAIL gap_underrun cyc %0d: got %b expected %b", i, ur_a, (i == 34));
                end
            end
        end
    endtask

    task automatic test_invert_msb();
        logic [7:0] exp_b [5] = '{8'b00_00_00_11, 8'b00_00_00_11, 8'b01_00_00_10, 8'b11_00_00_00, 8'b11_00_00_00};
        while (m_phase != 0) tick(1'b0, '0, 1'b0);
        b_if.load_valid = 1'b1;
        b_if.load_words = {10'b1111100000, 10'h000, 10'h000, 10'b1111100000};
        tick(1'b0, '0, 1'b0);
        b_if.load_valid = 1'b0;
        b_if.load_words = '0;
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (pair_b !== exp_b[k]) begin
                n_fail++;
                $display("FAIL invert_msb pair %0d: got %b expected %b", k, pair_b, exp_b[k]);
            end
            tick(1'b0, '0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_symbol();
        for (int g = 0; g < 12 && !(m_phase == 2 && sb_q.size() == 1); g++) begin
            tick(1'b1, {CH{10'h3FF}}, 1'b0);
        end
        a_if.load_valid = 1'b0;
        #2;
        areset = 1'b1;
        #1;
        n_checks++;
        if ({pair_a, a_if.load_ready, ws_a, ur_a, pair_b} !== {8'h00, 3'b100, 8'hC0}) begin
            n_fail++;
            $display("FAIL midreset_async: got %h expected %h", {pair_a, a_if.load_ready, ws_a, ur_a, pair_b}, {8'h00, 3'b100, 8'hC0});
        end
        model_reset();
        @(posedge clock); #1;
        areset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, '0, 1'b0);
            n_checks++;
            if ({pair_a, a_if.load_ready, ws_a, ur_a} !== exp_vec()) begin
                n_fail++;
                $display("FAIL midreset_vec cyc %0d: got %h expected %h", i, {pair_a, a_if.load_ready, ws_a, ur_a}, exp_vec());
            end
            n_checks++;
            if ({pair_a, ur_a} !== {{CH{idle_pairs[i % 5]}}, 1'b1}) begin
                n_fail++;
                $display("FAIL midreset_idle cyc %0d: got %h expected %h", i, {pair_a, ur_a}, {{CH{idle_pairs[i % 5]}}, 1'b1});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rnd_set[i] = 40'({$urandom(), $urandom()});
        test_reset();
        test_idle_after_reset();
        test_stream();
        test_back_to_back();
        test_gap_underrun();
        test_invert_msb();
        test_reset_mid_symbol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
